// File: rtl/lcd_hd44780_writer.sv
// HD44780 character LCD writer: power-on wait, 4-command init, then endless
// refresh of a 2x16 frame from a snapshot of msg.
module lcd_hd44780_writer #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned CMD_CYC     = 2500,
  parameter int unsigned CLEAR_CYC   = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] msg,
  output logic         disp_rs,
  output logic         disp_rw,
  output logic         disp_en,
  output logic [7:0]   disp_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int unsigned MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] POWERUP_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST      = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST     = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST   = CW'(CLEAR_CYC - 1);

  // INIT, FRAME_START and NEXT each occupy the first setup cycle of the
  // transaction they launch, so consecutive transactions have no gap.
  localparam logic [2:0] PWR_WAIT    = 3'd0;
  localparam logic [2:0] INIT        = 3'd1;
  localparam logic [2:0] FRAME_START = 3'd2;
  localparam logic [2:0] XFER_SETUP  = 3'd3;
  localparam logic [2:0] XFER_EN     = 3'd4;
  localparam logic [2:0] XFER_WAIT   = 3'd5;
  localparam logic [2:0] NEXT        = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [1:0]    init_step_q, init_step_d;
  logic          line_cmd_q, line_cmd_d;
  logic [255:0]  snap_q, snap_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;

  logic [4:0]    idx_inc;
  logic [7:0]    char_cur;
  logic [7:0]    char_inc;
  logic [CW-1:0] wait_last;
  logic          start_frame;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Character i lives at msg[255-8i -: 8], i.e. bit offset (31-i)*8 = {~i,3'b0}.
  assign idx_inc   = idx_q + 5'd1;
  assign char_cur  = snap_q[{~idx_q, 3'b000} +: 8];
  assign char_inc  = snap_q[{~idx_inc, 3'b000} +: 8];
  assign wait_last = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;

  // Next-state, transaction sequencing and next-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    init_step_d  = init_step_q;
    line_cmd_d   = line_cmd_q;
    snap_d       = snap_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    start_frame  = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == POWERUP_LAST) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_step_d = 2'd0;
          rs_d        = 1'b0;
          data_d      = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      INIT, FRAME_START, NEXT, XFER_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = XFER_EN;
          cnt_d   = '0;
        end else begin
          state_d = XFER_SETUP;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      XFER_EN: begin
        if (cnt_q == EN_LAST) begin
          state_d = XFER_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      XFER_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!init_done_q) begin
            if (init_step_q == 2'd3) begin
              start_frame = 1'b1;
            end else begin
              state_d     = INIT;
              init_step_d = init_step_q + 2'd1;
              rs_d        = 1'b0;
              data_d      = init_cmd(init_step_q + 2'd1);
            end
          end else if (line_cmd_q) begin
            state_d    = NEXT;
            line_cmd_d = 1'b0;
            rs_d       = 1'b1;
            data_d     = char_cur;
          end else if (idx_q == 5'd31) begin
            start_frame = 1'b1;
          end else if (idx_q == 5'd15) begin
            state_d    = NEXT;
            line_cmd_d = 1'b1;
            idx_d      = 5'd16;
            rs_d       = 1'b0;
            data_d     = 8'hC0;
          end else begin
            state_d = NEXT;
            idx_d   = idx_inc;
            rs_d    = 1'b1;
            data_d  = char_inc;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Frame start: snapshot msg and launch the line-1 address command.
    if (start_frame) begin
      state_d     = FRAME_START;
      snap_d      = msg;
      idx_d       = 5'd0;
      line_cmd_d  = 1'b1;
      rs_d        = 1'b0;
      data_d      = 8'h80;
      init_done_d = 1'b1;
    end

    en_d         = (state_d == XFER_EN);
    frame_done_d = init_done_q && !line_cmd_q && (idx_q == 5'd31) &&
                   (state_d == XFER_WAIT) && (cnt_d == CMD_LAST);
  end

  // State and output registers; reset clears EN asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PWR_WAIT;
      cnt_q        <= '0;
      idx_q        <= 5'd0;
      init_step_q  <= 2'd0;
      line_cmd_q   <= 1'b0;
      snap_q       <= '0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      init_step_q  <= init_step_d;
      line_cmd_q   <= line_cmd_d;
      snap_q       <= snap_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      en_q         <= en_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp_rs    = rs_q;
  assign disp_rw    = 1'b0;
  assign disp_en    = en_q;
  assign disp_data  = data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Bench for lcd_hd44780_writer: cycle-by-cycle comparison against a
// transaction-list model, plus directed byte, strobe and reset checks.
module tb_lcd_hd44780_writer;

  localparam int P_PWR = 20;
  localparam int P_SET = 2;
  localparam int P_EN  = 3;
  localparam int P_CMD = 5;
  localparam int P_CLR = 9;
  localparam int TXN   = P_SET + P_EN + P_CMD;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] msg;
  logic         disp_rs, disp_rw, disp_en, init_done, frame_done;
  logic [7:0]   disp_data;

  always #5 clk = ~clk;

  lcd_hd44780_writer #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .EN_CYC(P_EN),
    .CMD_CYC(P_CMD), .CLEAR_CYC(P_CLR)
  ) dut (
    .clk(clk), .rst(rst), .msg(msg),
    .disp_rs(disp_rs), .disp_rw(disp_rw), .disp_en(disp_en),
    .disp_data(disp_data), .init_done(init_done), .frame_done(frame_done)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: cycle t since reset release, current transaction and its start.
  int           t;
  int           seq;
  int           cur_start;
  int           cur_wait;
  logic [8:0]   cur_b;
  logic [255:0] snap;
  logic [7:0]   init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Observations
  int         first_rise, rise_t, en_w_min, en_w_max, fd_w_max;
  logic       en_prev, fd_prev;
  logic [8:0] en_log[$];
  int         fd_rises[$];

  logic [255:0] welcome, enter_msg, rnd;
  int           log_base;
  bit           found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
    end
  endtask

  // Frame slot k: 0 -> 0x80, 1..16 -> chars 0..15, 17 -> 0xC0, 18..33 -> chars 16..31.
  function automatic logic [8:0] frame_byte(input logic [255:0] m, input int k);
    int ch;
    if (k == 0)  return 9'h080;
    if (k == 17) return 9'h0C0;
    ch = (k < 17) ? k - 1 : k - 2;
    return {1'b1, m[255 - 8*ch -: 8]};
  endfunction

  task automatic model_reset();
    t = 0; seq = -1; cur_start = 0; cur_wait = 0; cur_b = '0;
    first_rise = -1; en_prev = 1'b0; fd_prev = 1'b0;
  endtask

  task automatic load_txn();
    int slot;
    if (seq < 4) begin
      cur_b    = {1'b0, init_cmds[seq]};
      cur_wait = (seq == 2) ? P_CLR : P_CMD;
    end else begin
      slot = (seq - 4) % 34;
      if (slot == 0) snap = msg;
      cur_b    = frame_byte(snap, slot);
      cur_wait = P_CMD;
    end
  endtask

  // One clock: advance the model, compare every output, update monitors.
  task automatic step();
    logic [12:0] exp_v, obs_v;
    int off, slot, w;
    logic e_en, e_fd;
    @(posedge clk);
    t = t + 1;
    @(negedge clk);
    if (t == P_PWR) begin
      seq = 0; cur_start = t; load_txn();
    end else if (seq >= 0 && t == cur_start + P_SET + P_EN + cur_wait) begin
      seq = seq + 1; cur_start = t; load_txn();
    end
    if (seq < 0) begin
      exp_v = '0;
    end else begin
      off   = t - cur_start;
      slot  = (seq >= 4) ? (seq - 4) % 34 : -1;
      e_en  = (off >= P_SET) && (off < P_SET + P_EN);
      e_fd  = (slot == 33) && (off == P_SET + P_EN + cur_wait - 1);
      exp_v = {e_en, cur_b, 1'b0, (seq >= 4), e_fd};
    end
    obs_v = {disp_en, disp_rs, disp_data, disp_rw, init_done, frame_done};
    check("cycle_outputs", 32'(obs_v), 32'(exp_v));

    if (disp_en && !en_prev) begin
      if (first_rise < 0) first_rise = t;
      en_log.push_back({disp_rs, disp_data});
      rise_t = t;
    end
    if (!disp_en && en_prev) begin
      w = t - rise_t;
      if (w < en_w_min) en_w_min = w;
      if (w > en_w_max) en_w_max = w;
    end
    if (frame_done && !fd_prev) fd_rises.push_back(t);
    if (!frame_done && fd_prev && (t - fd_rises[$] > fd_w_max)) fd_w_max = t - fd_rises[$];
    en_prev = disp_en;
    fd_prev = frame_done;
  endtask

  task automatic run_to(input int t_end);
    while (t < t_end) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    welcome   = "Welcome to the  Text Encryptor  ";
    enter_msg = {"Enter [63:48]key", {16{8'h20}}};
    en_w_min  = 1000; en_w_max = 0; fd_w_max = 0;
    model_reset();

    rst = 1'b1; msg = welcome;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({disp_en, disp_rs, disp_rw, disp_data, init_done, frame_done}), 32'd0);

    rst = 1'b1;
    run_to(150);
    msg = enter_msg;              // mid line 1 of frame 1
    run_to(500);
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    rnd[255 - 8*5 -: 8] = 8'h00;
    rnd[7:0] = 8'h00;
    msg = rnd;
    run_to(900);
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    msg = rnd;
    run_to(1200);
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    msg = rnd;
    run_to(1500);

    check("first_en_rise", 32'(first_rise), 32'(P_PWR + P_SET));
    check("en_width_min", 32'(en_w_min), 32'(P_EN));
    check("en_width_max", 32'(en_w_max), 32'(P_EN));
    check("en_log_size", 32'(en_log.size() >= 106), 32'd1);
    if (en_log.size() >= 106) begin
      for (int k = 0; k < 4; k++) check("init_cmd", 32'(en_log[k]), 32'({1'b0, init_cmds[k]}));
      for (int k = 0; k < 34; k++) check("welcome_frame", 32'(en_log[4 + k]), 32'(frame_byte(welcome, k)));
      for (int k = 0; k < 34; k++) check("snapshot_frame", 32'(en_log[38 + k]), 32'(frame_byte(enter_msg, k)));
      check("zero_byte_char5", 32'(en_log[72 + 6]), 32'h100);
      check("zero_byte_char31", 32'(en_log[72 + 33]), 32'h100);
    end
    check("frame_done_count", 32'(fd_rises.size()), 32'd4);
    if (fd_rises.size() >= 4) begin
      check("frame_done_first", 32'(fd_rises[0]), 32'(P_PWR + 4*TXN + 4 + 34*TXN - 1));
      for (int k = 1; k < 4; k++)
        check("frame_done_spacing", 32'(fd_rises[k] - fd_rises[k-1]), 32'(34 * TXN));
    end
    check("frame_done_width", 32'(fd_w_max), 32'd1);

    // Reset during an EN-high cycle of character 10 (frame slot 11).
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (seq >= 4 && (seq - 4) % 34 == 11 && (t - cur_start) >= P_SET &&
          (t - cur_start) < P_SET + P_EN) found = 1'b1;
    end
    check("char10_reached", 32'(found), 32'd1);
    check("char10_en_high", 32'(disp_en), 32'd1);
    check("char10_byte", 32'({disp_rs, disp_data}), 32'(frame_byte(snap, 11)));
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'({disp_en, disp_rs, disp_rw, disp_data, init_done, frame_done}), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_hold_outputs", 32'({disp_en, disp_rs, disp_rw, disp_data, init_done, frame_done}), 32'd0);

    log_base = en_log.size();
    model_reset();
    rst = 1'b1;
    run_to(P_PWR + 2*TXN + 20);
    check("restart_first_rise", 32'(first_rise), 32'(P_PWR + P_SET));
    check("restart_log", 32'(en_log.size() > log_base), 32'd1);
    if (en_log.size() > log_base) check("restart_cmd", 32'(en_log[log_base]), 32'h038);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
